// File: rtl/lock_pkg.sv
// Shared types and helpers for the combination-lock front end.
//   state_t        : sequencing states of code_entry
//   onehot_to_idx  : binary index of the set bit of a one-hot vector (up to 32 bits)
//   DEF_*          : default parameter values
package lock_pkg;

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        CHECK,
        UNLOCK,
        LOCKOUT
    } state_t;

    localparam int DEF_N_BUTTONS      = 4;
    localparam int DEF_CODE_LEN       = 2;
    localparam int DEF_TIMEOUT_CYCLES = 50_000_000;
    localparam int DEF_UNLOCK_CYCLES  = 100_000_000;
    localparam int DEF_MAX_FAILS      = 3;
    localparam int DEF_LOCKOUT_CYCLES = 500_000_000;

    // OR-reduction encoder: correct only when exactly one bit is set, which
    // the caller guarantees before using the result.
    function automatic logic [4:0] onehot_to_idx(input logic [31:0] onehot);
        logic [4:0] idx;
        idx = '0;
        for (int i = 0; i < 32; i++) begin
            if (onehot[i]) idx = idx | 5'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Button input path: 2-flop synchroniser per button, rising-edge detect
// against the previous synchronised value, single-press qualification and
// one-hot to binary encode. Result is registered.
//   clk, rst_n   : clock, async active-low reset
//   btn          : raw asynchronous active-high buttons
//   press_valid  : one-cycle pulse, exactly one button rose
//   press_idx    : index of that button (0 when press_valid is low)
module btn_sync_edge
    import lock_pkg::*;
#(
    parameter int N_BUTTONS = DEF_N_BUTTONS
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [N_BUTTONS-1:0]         btn,
    output logic                         press_valid,
    output logic [$clog2(N_BUTTONS)-1:0] press_idx
);

    localparam int IDX_W = $clog2(N_BUTTONS);

    logic [N_BUTTONS-1:0] sync1_q, sync1_d;
    logic [N_BUTTONS-1:0] sync2_q, sync2_d;
    logic [N_BUTTONS-1:0] hist_q,  hist_d;
    logic                 press_valid_q, press_valid_d;
    logic [IDX_W-1:0]     press_idx_q,   press_idx_d;
    logic [N_BUTTONS-1:0] rise;
    logic                 single;

    // NOTE: every combinational output gets a default before any branch so no
    // path leaves it unassigned -- that is what keeps latches from appearing.
    always_comb begin
        sync1_d = btn;
        sync2_d = sync1_q;
        hist_d  = sync2_q;
        rise    = sync2_q & ~hist_q;
        // Power-of-two test: non-zero with no second bit set.
        single  = (rise != '0) && ((rise & (rise - N_BUTTONS'(1))) == '0);
        press_valid_d = single;
        press_idx_d   = single ? IDX_W'(onehot_to_idx(32'(rise))) : '0;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q       <= '0;
            sync2_q       <= '0;
            hist_q        <= '0;
            press_valid_q <= 1'b0;
            press_idx_q   <= '0;
        end else begin
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            hist_q        <= hist_d;
            press_valid_q <= press_valid_d;
            press_idx_q   <= press_idx_d;
        end
    end

    assign press_valid = press_valid_q;
    assign press_idx   = press_idx_q;

endmodule

// File: rtl/code_entry.sv
// Lock sequencing: collects CODE_LEN button presses into `entered`, samples
// the comparator's `match` for one CHECK cycle, then opens the lock or counts
// a failure, entering lockout after MAX_FAILS consecutive failures.
//   clk, rst_n     : clock, async active-low reset
//   btn            : raw buttons
//   clear          : abort current attempt (COLLECT) or end UNLOCK early
//   match          : combinational comparator result for `entered`
//   entered        : assembled code, first press in the MSBs
//   entered_valid  : high during the CHECK cycle
//   digit_count    : presses accepted in this attempt
//   unlock         : lock-open level
//   fail_count     : consecutive failed attempts
//   locked_out     : high while input is ignored
module code_entry
    import lock_pkg::*;
#(
    parameter int N_BUTTONS      = DEF_N_BUTTONS,
    parameter int CODE_LEN       = DEF_CODE_LEN,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int UNLOCK_CYCLES  = DEF_UNLOCK_CYCLES,
    parameter int MAX_FAILS      = DEF_MAX_FAILS,
    parameter int LOCKOUT_CYCLES = DEF_LOCKOUT_CYCLES
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic [N_BUTTONS-1:0]                    btn,
    input  logic                                    clear,
    input  logic                                    match,
    output logic [CODE_LEN*$clog2(N_BUTTONS)-1:0]   entered,
    output logic                                    entered_valid,
    output logic [$clog2(CODE_LEN+1)-1:0]           digit_count,
    output logic                                    unlock,
    output logic [$clog2(MAX_FAILS+1)-1:0]          fail_count,
    output logic                                    locked_out
);

    localparam int IDX_W = $clog2(N_BUTTONS);
    localparam int W     = CODE_LEN * IDX_W;
    localparam int DC_W  = $clog2(CODE_LEN + 1);
    localparam int FC_W  = $clog2(MAX_FAILS + 1);

    // One duty counter covers the longest of the three timed intervals.
    localparam int MAX_CYC_A = (TIMEOUT_CYCLES > UNLOCK_CYCLES) ? TIMEOUT_CYCLES : UNLOCK_CYCLES;
    localparam int MAX_CYC   = (MAX_CYC_A > LOCKOUT_CYCLES) ? MAX_CYC_A : LOCKOUT_CYCLES;
    localparam int CNT_W     = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    logic             press_valid;
    logic [IDX_W-1:0] press_idx;

    state_t           state_q,       state_d;
    logic [CNT_W-1:0] cnt_q,         cnt_d;
    logic [W-1:0]     entered_q,     entered_d;
    logic [DC_W-1:0]  digit_count_q, digit_count_d;
    logic [FC_W-1:0]  fail_count_q,  fail_count_d;
    logic             unlock_q,      unlock_d;
    logic             locked_out_q,  locked_out_d;

    btn_sync_edge #(
        .N_BUTTONS (N_BUTTONS)
    ) u_btn (
        .clk         (clk),
        .rst_n       (rst_n),
        .btn         (btn),
        .press_valid (press_valid),
        .press_idx   (press_idx)
    );

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        entered_d     = entered_q;
        digit_count_d = digit_count_q;
        fail_count_d  = fail_count_q;

        unique case (state_q)
            IDLE: begin
                if (press_valid) begin
                    entered_d     = W'(press_idx);
                    digit_count_d = DC_W'(1);
                    state_d       = (CODE_LEN == 1) ? CHECK : COLLECT;
                end
            end

            COLLECT: begin
                if (clear || (!press_valid && cnt_q == CNT_W'(TIMEOUT_CYCLES - 1))) begin
                    // Abandoned attempt: not a failure, fail_count untouched.
                    entered_d     = '0;
                    digit_count_d = '0;
                    state_d       = IDLE;
                end else if (press_valid) begin
                    // Size cast keeps the low W bits, dropping the oldest digit.
                    entered_d     = W'({entered_q, press_idx});
                    digit_count_d = digit_count_q + DC_W'(1);
                    cnt_d         = '0;
                    if (digit_count_q + DC_W'(1) == DC_W'(CODE_LEN)) state_d = CHECK;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            CHECK: begin
                digit_count_d = '0;
                if (match) begin
                    fail_count_d = '0;
                    state_d      = UNLOCK;
                end else if (fail_count_q + FC_W'(1) == FC_W'(MAX_FAILS)) begin
                    fail_count_d = FC_W'(MAX_FAILS);
                    state_d      = LOCKOUT;
                end else begin
                    fail_count_d = fail_count_q + FC_W'(1);
                    state_d      = IDLE;
                end
            end

            UNLOCK: begin
                if (clear || cnt_q == CNT_W'(UNLOCK_CYCLES - 1)) state_d = IDLE;
                else                                             cnt_d   = cnt_q + CNT_W'(1);
            end

            LOCKOUT: begin
                if (cnt_q == CNT_W'(LOCKOUT_CYCLES - 1)) begin
                    fail_count_d = '0;
                    state_d      = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: state_d = IDLE;
        endcase

        if (state_d != state_q) cnt_d = '0;

        // Level outputs track the state being entered so they are flops.
        unlock_d     = (state_d == UNLOCK);
        locked_out_d = (state_d == LOCKOUT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            entered_q     <= '0;
            digit_count_q <= '0;
            fail_count_q  <= '0;
            unlock_q      <= 1'b0;
            locked_out_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            entered_q     <= entered_d;
            digit_count_q <= digit_count_d;
            fail_count_q  <= fail_count_d;
            unlock_q      <= unlock_d;
            locked_out_q  <= locked_out_d;
        end
    end

    assign entered       = entered_q;
    assign entered_valid = (state_q == CHECK);
    assign digit_count   = digit_count_q;
    assign unlock        = unlock_q;
    assign fail_count    = fail_count_q;
    assign locked_out    = locked_out_q;

endmodule

// File: tb/tb_code_entry.sv
module tb_code_entry;

    logic       clk;
    logic       rst_n;
    logic [3:0] btn;
    logic       clear;
    logic       match;
    logic [3:0] entered;
    logic       entered_valid;
    logic [1:0] digit_count;
    logic       unlock;
    logic [1:0] fail_count;
    logic       locked_out;

    int n_cmp;
    int n_mis;

    // Activity seen on sampling edges since the last clear_counts.
    int         ev_cnt;
    int         unl_cnt;
    int         lo_cnt;
    logic [3:0] ent_at_ev;

    code_entry #(
        .N_BUTTONS      (4),
        .CODE_LEN       (2),
        .TIMEOUT_CYCLES (20),
        .UNLOCK_CYCLES  (10),
        .MAX_FAILS      (3),
        .LOCKOUT_CYCLES (30)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .btn           (btn),
        .clear         (clear),
        .match         (match),
        .entered       (entered),
        .entered_valid (entered_valid),
        .digit_count   (digit_count),
        .unlock        (unlock),
        .fail_count    (fail_count),
        .locked_out    (locked_out)
    );

    // Comparator model: secret code is button 3 then button 2.
    assign match = (entered == 4'b1110);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_counts();
        ev_cnt    = 0;
        unl_cnt   = 0;
        lo_cnt    = 0;
        ent_at_ev = 4'hx;
    endtask

    // Advance to the next falling edge and record what the DUT shows there.
    task automatic step();
        @(negedge clk);
        if (entered_valid === 1'b1) begin
            ev_cnt++;
            ent_at_ev = entered;
        end
        if (unlock === 1'b1)     unl_cnt++;
        if (locked_out === 1'b1) lo_cnt++;
    endtask

    task automatic watch(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    // Button held across three sampling edges, then released; the digit lands
    // on the 4th rising edge, so a final-digit CHECK cycle is sampled by the
    // first step after release.
    task automatic press(input int i);
        btn[i] = 1'b1;
        watch(3);
        btn[i] = 1'b0;
        watch(2);
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        btn   = '0;
        clear = 1'b0;
        clear_counts();
        watch(3);
        n_cmp++;
        if ({entered, entered_valid, digit_count, unlock, fail_count, locked_out} !== 11'd0) begin
            n_mis++;
            $display("FAIL reset_outputs: got %b want all zero",
                     {entered, entered_valid, digit_count, unlock, fail_count, locked_out});
        end
        rst_n = 1'b1;
        watch(2);
    endtask

    task automatic test_correct_code();
        clear_counts();
        press(3);
        n_cmp++;
        if (digit_count !== 2'd1 || entered !== 4'b0011) begin
            n_mis++;
            $display("FAIL first_digit: digit_count=%0d entered=%b want 1 / 0011", digit_count, entered);
        end
        press(2);
        watch(20);
        n_cmp++;
        if (ev_cnt !== 1 || ent_at_ev !== 4'b1110) begin
            n_mis++;
            $display("FAIL correct_check: valid_cycles=%0d entered=%b want 1 / 1110", ev_cnt, ent_at_ev);
        end
        n_cmp++;
        if (unl_cnt !== 10) begin
            n_mis++;
            $display("FAIL unlock_len: got %0d cycles want 10", unl_cnt);
        end
        n_cmp++;
        if (fail_count !== 2'd0 || digit_count !== 2'd0 || entered !== 4'b1110) begin
            n_mis++;
            $display("FAIL after_unlock: fail=%0d digits=%0d entered=%b want 0 / 0 / 1110",
                     fail_count, digit_count, entered);
        end
    endtask

    task automatic test_lockout();
        clear_counts();
        for (int a = 1; a <= 3; a++) begin
            press(0);
            press(1);
            n_cmp++;
            if (fail_count !== 2'(a) || locked_out !== (a == 3)) begin
                n_mis++;
                $display("FAIL fail_step%0d: fail=%0d locked=%b want %0d / %0d",
                         a, fail_count, locked_out, a, (a == 3));
            end
        end
        // Presses while locked out must not be accepted.
        press(3);
        press(2);
        n_cmp++;
        if (digit_count !== 2'd0 || locked_out !== 1'b1 || ev_cnt !== 3 || unl_cnt !== 0) begin
            n_mis++;
            $display("FAIL lockout_ignore: digits=%0d locked=%b checks=%0d unlocks=%0d want 0 / 1 / 3 / 0",
                     digit_count, locked_out, ev_cnt, unl_cnt);
        end
        watch(40);
        n_cmp++;
        if (lo_cnt !== 30 || fail_count !== 2'd0 || locked_out !== 1'b0) begin
            n_mis++;
            $display("FAIL lockout_end: cycles=%0d fail=%0d locked=%b want 30 / 0 / 0",
                     lo_cnt, fail_count, locked_out);
        end
        // Back in IDLE: a press is accepted as a first digit.
        press(1);
        n_cmp++;
        if (digit_count !== 2'd1 || entered !== 4'b0001) begin
            n_mis++;
            $display("FAIL post_lockout_idle: digits=%0d entered=%b want 1 / 0001", digit_count, entered);
        end
        pulse_clear();
        watch(2);
    endtask

    task automatic test_timeout();
        clear_counts();
        press(3);
        // Digit stored 1.5 cycles before press() returns; timeout fires on
        // the 20th edge after storage.
        watch(18);
        n_cmp++;
        if (digit_count !== 2'd1) begin
            n_mis++;
            $display("FAIL timeout_early: digits=%0d want 1", digit_count);
        end
        watch(1);
        n_cmp++;
        if (digit_count !== 2'd0 || entered !== 4'b0000 || ev_cnt !== 0 || fail_count !== 2'd0) begin
            n_mis++;
            $display("FAIL timeout: digits=%0d entered=%b checks=%0d fail=%0d want 0 / 0000 / 0 / 0",
                     digit_count, entered, ev_cnt, fail_count);
        end
    endtask

    task automatic test_simultaneous();
        clear_counts();
        btn[3] = 1'b1;
        btn[1] = 1'b1;
        watch(5);
        btn = '0;
        watch(3);
        n_cmp++;
        if (digit_count !== 2'd0 || entered !== 4'b0000) begin
            n_mis++;
            $display("FAIL simultaneous: digits=%0d entered=%b want 0 / 0000", digit_count, entered);
        end
        // Long hold: one digit, and no second capture after it times out.
        btn[3] = 1'b1;
        watch(10);
        n_cmp++;
        if (digit_count !== 2'd1 || entered !== 4'b0011) begin
            n_mis++;
            $display("FAIL held_one: digits=%0d entered=%b want 1 / 0011", digit_count, entered);
        end
        watch(40);
        n_cmp++;
        if (digit_count !== 2'd0 || ev_cnt !== 0) begin
            n_mis++;
            $display("FAIL held_no_repeat: digits=%0d checks=%0d want 0 / 0", digit_count, ev_cnt);
        end
        btn[3] = 1'b0;
        watch(3);
        press(2);
        n_cmp++;
        if (digit_count !== 2'd1 || entered !== 4'b0010) begin
            n_mis++;
            $display("FAIL after_release: digits=%0d entered=%b want 1 / 0010", digit_count, entered);
        end
        pulse_clear();
        watch(2);
    endtask

    task automatic test_clear_and_reset();
        clear_counts();
        press(3);
        pulse_clear();
        n_cmp++;
        if (digit_count !== 2'd0 || entered !== 4'b0000 || fail_count !== 2'd0) begin
            n_mis++;
            $display("FAIL clear_mid_entry: digits=%0d entered=%b fail=%0d want 0 / 0000 / 0",
                     digit_count, entered, fail_count);
        end
        press(3);
        press(2);
        watch(2);
        n_cmp++;
        if (unlock !== 1'b1) begin
            n_mis++;
            $display("FAIL unlock_before_reset: got %b want 1", unlock);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({entered, entered_valid, digit_count, unlock, fail_count, locked_out} !== 11'd0) begin
            n_mis++;
            $display("FAIL reset_mid_unlock: got %b want all zero",
                     {entered, entered_valid, digit_count, unlock, fail_count, locked_out});
        end
        @(negedge clk);
        rst_n = 1'b1;
        watch(2);
    endtask

    initial begin
        n_cmp = 0;
        n_mis = 0;
        test_reset();
        test_correct_code();
        test_lockout();
        test_timeout();
        test_simultaneous();
        test_clear_and_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
